pwm_ramp_ctrl: RTL and testbench

Autonomous sequencer that drives the pwm register bus (addr/data/event) to ramp the PWM duty cycle from its current value to a target value.
- Writes ctl0 to enable the PWM and select the dither shift, then steps the duty every cfg_period_i clocks by cfg_step_i until the target is reached.
- Sits between the system config registers and the pwm peripheral, replacing software-timed duty writes for fades.

---
 rtl/pwm_ramp_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pwm_ramp_ctrl
// Function : Ramps the pwm duty register to a target over the pwm register bus.
//            Optional duty readback check: define PWM_RAMP_CTRL_READBACK_EN.
// Revision : 1.0
// ============================================================================
module pwm_ramp_ctrl #(
  parameter int PWM_BITS = 10,
  parameter int PERIOD_W = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic [PWM_BITS-1:0] cfg_target_i,
  input  logic [7:0]          cfg_step_i,
  input  logic [PERIOD_W-1:0] cfg_period_i,
  input  logic [1:0]          cfg_ss_i,
  output logic [7:0]          b_addr_o,
  output logic [7:0]          b_data_o,
  output logic [1:0]          b_event_o,
  input  logic [7:0]          b_data_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic [PWM_BITS-1:0] duty_o
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_CTL_WR  = 4'd1,
    S_WAIT    = 4'd2,
    S_STEP    = 4'd3,
    S_WR_HI   = 4'd4,
    S_WR_LO   = 4'd5,
    S_VERIFY  = 4'd6,
    S_DONE    = 4'd7,
    S_STOP_WR = 4'd8
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [PWM_BITS-1:0] r_cur, r_target, w_cur_nxt, w_step_val;
  logic [7:0]          r_step;
  logic [PERIOD_W-1:0] r_period, r_cnt, w_cnt_nxt;
  logic [7:0]          r_addr, r_data;
  logic [1:0]          r_event;
  logic                r_busy, r_done;
  logic [PWM_BITS:0]   w_cur_x, w_tgt_x, w_stp_x, w_sum, w_diff;
  logic [15:0]         w_nxt_ext;

`ifdef PWM_RAMP_CTRL_READBACK_EN
  logic r_err, w_err_set;
`else
  logic w_unused_rdata;
  assign w_unused_rdata = ^b_data_i;
`endif

  // One extra bit so the up-step cannot overflow and the down-step can detect underflow.
  assign w_cur_x = {1'b0, r_cur};
  assign w_tgt_x = {1'b0, r_target};
  assign w_stp_x = {{(PWM_BITS-7){1'b0}}, r_step};
  assign w_sum   = w_cur_x + w_stp_x;
  assign w_diff  = w_cur_x - w_stp_x;

  always_comb begin
    w_step_val = r_target;
    if (r_cur < r_target) begin
      if (w_sum < w_tgt_x) w_step_val = w_sum[PWM_BITS-1:0];
    end else if (r_cur > r_target) begin
      if (w_cur_x >= w_stp_x && w_diff > w_tgt_x) w_step_val = w_diff[PWM_BITS-1:0];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cur_nxt   = r_cur;
`ifdef PWM_RAMP_CTRL_READBACK_EN
    w_err_set   = 1'b0;
`endif
    case (r_state)
      S_IDLE:   if (start_i) w_state_nxt = S_CTL_WR;
      S_CTL_WR: begin
        if (r_cur == r_target) begin
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt   = r_period;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt - PERIOD_W'(1);
        if (r_cnt <= PERIOD_W'(1)) w_state_nxt = S_STEP;
      end
      S_STEP: begin
        w_cur_nxt   = w_step_val;
        w_state_nxt = S_WR_HI;
      end
      S_WR_HI:  w_state_nxt = S_WR_LO;
`ifdef PWM_RAMP_CTRL_READBACK_EN
      S_WR_LO:  w_state_nxt = S_VERIFY;
      S_VERIFY: begin
        if (b_data_i != r_cur[7:0]) begin
          w_err_set   = 1'b1;
          w_state_nxt = S_STOP_WR;
        end else if (r_cur == r_target) begin
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt   = r_period;
          w_state_nxt = S_WAIT;
        end
      end
`else
      S_WR_LO: begin
        if (r_cur == r_target) begin
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt   = r_period;
          w_state_nxt = S_WAIT;
        end
      end
`endif
      S_DONE:    w_state_nxt = S_IDLE;
      S_STOP_WR: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
    // Abort wins over everything; the duty in flight is left as-is.
    if (stop_i && r_state != S_IDLE) begin
      w_state_nxt = S_STOP_WR;
      w_cur_nxt   = r_cur;
    end
  end

  assign w_nxt_ext = 16'(w_cur_nxt);

  // Bus outputs are registered from the state being entered so they line up with it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_cur    <= '0;
      r_cnt    <= '0;
      r_target <= '0;
      r_step   <= '0;
      r_period <= '0;
      r_addr   <= '0;
      r_data   <= '0;
      r_event  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
`ifdef PWM_RAMP_CTRL_READBACK_EN
      r_err    <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cur   <= w_cur_nxt;
      r_cnt   <= w_cnt_nxt;
      if (r_state == S_IDLE && start_i) begin
        r_target <= cfg_target_i;
        r_step   <= (cfg_step_i == 8'd0) ? 8'd1 : cfg_step_i;
        r_period <= (cfg_period_i == '0) ? PERIOD_W'(1) : cfg_period_i;
      end
      r_addr  <= 8'h00;
      r_data  <= 8'h00;
      r_event <= 2'b00;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= (w_state_nxt == S_DONE);
      case (w_state_nxt)
        S_CTL_WR: begin
          r_data  <= {1'b1, 5'b0, cfg_ss_i};
          r_event <= 2'b10;
        end
        S_WR_HI: begin
          r_addr  <= 8'h01;
          r_data  <= w_nxt_ext[15:8];
          r_event <= 2'b10;
        end
        S_WR_LO: begin
          r_addr  <= 8'h10;
          r_data  <= w_nxt_ext[7:0];
          r_event <= 2'b10;
        end
`ifdef PWM_RAMP_CTRL_READBACK_EN
        S_VERIFY: begin
          r_addr  <= 8'h10;
          r_event <= 2'b01;
        end
`endif
        S_STOP_WR: r_event <= 2'b10;
        default: ;
      endcase
`ifdef PWM_RAMP_CTRL_READBACK_EN
      if (w_err_set) r_err <= 1'b1;
`endif
    end
  end

  assign b_addr_o  = r_addr;
  assign b_data_o  = r_data;
  assign b_event_o = r_event;
  assign busy_o    = r_busy;
  assign done_o    = r_done;
  assign duty_o    = r_cur;
`ifdef PWM_RAMP_CTRL_READBACK_EN
  assign err_o     = r_err;
`else
  assign err_o     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pwm_ramp_ctrl.sv
`default_nettype none
// tb_pwm_ramp_ctrl: directed and randomized ramps checked against an arithmetic duty model.
module tb_pwm_ramp_ctrl;
  localparam int PW  = 10;
  localparam int PRW = 16;
`ifdef PWM_RAMP_CTRL_READBACK_EN
  localparam int VER = 1;
`else
  localparam int VER = 0;
`endif

  logic           clk_i = 1'b0;
  logic           rst_i = 1'b1, start_i = 1'b0, stop_i = 1'b0;
  logic [PW-1:0]  cfg_target_i = '0;
  logic [7:0]     cfg_step_i = '0;
  logic [PRW-1:0] cfg_period_i = '0;
  logic [1:0]     cfg_ss_i = '0;
  logic [7:0]     b_addr_o, b_data_o, b_data_i;
  logic [1:0]     b_event_o;
  logic           busy_o, done_o, err_o;
  logic [PW-1:0]  duty_o;

  always #5 clk_i = ~clk_i;

  pwm_ramp_ctrl #(.PWM_BITS(PW), .PERIOD_W(PRW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i),
    .cfg_target_i(cfg_target_i), .cfg_step_i(cfg_step_i), .cfg_period_i(cfg_period_i),
    .cfg_ss_i(cfg_ss_i), .b_addr_o(b_addr_o), .b_data_o(b_data_o), .b_event_o(b_event_o),
    .b_data_i(b_data_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .duty_o(duty_o)
  );

  int checks = 0, errors = 0, cyc = 0, m_cur = 0;
  logic exp_err = 1'b0;
  typedef struct { int cyc; int addr; int data; int ev; } op_t;
  op_t ops[$];
  int  dones[$];
  int  exp_d[$];

  // Peripheral model: the lo duty register reads back what was last written.
  logic [7:0] pwm_lo = 8'h00;
  logic       force_bad = 1'b0;
  always @(posedge clk_i) if (b_event_o == 2'b10 && b_addr_o == 8'h10) pwm_lo <= b_data_o;
  assign b_data_i = force_bad ? 8'hFF : pwm_lo;

  always @(negedge clk_i) begin
    cyc = cyc + 1;
    if (b_event_o != 2'b00) ops.push_back('{cyc, int'(b_addr_o), int'(b_data_o), int'(b_event_o)});
    if (done_o) dones.push_back(cyc);
  end

  function automatic void build_model(input int cur, input int tgt, input int step);
    int s;
    s = (step == 0) ? 1 : step;
    exp_d.delete();
    while (cur != tgt) begin
      if (cur < tgt) cur = (cur + s > tgt) ? tgt : cur + s;
      else           cur = (cur - s < tgt) ? tgt : cur - s;
      exp_d.push_back(cur);
    end
  endfunction

  task automatic pulse_start(input int tgt, input int step, input int per, input int ss, input logic stp);
    @(negedge clk_i);
    cfg_target_i = tgt[PW-1:0];
    cfg_step_i   = step[7:0];
    cfg_period_i = per[PRW-1:0];
    cfg_ss_i     = ss[1:0];
    start_i = 1'b1;
    stop_i  = stp;
    @(negedge clk_i);
    start_i = 1'b0;
    stop_i  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    m_cur = 0;
    exp_err = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    checks++; if (b_addr_o !== 8'h00)  begin errors++; $display("FAIL reset_addr got %0h want 0", b_addr_o); end
    checks++; if (b_data_o !== 8'h00)  begin errors++; $display("FAIL reset_data got %0h want 0", b_data_o); end
    checks++; if (b_event_o !== 2'b00) begin errors++; $display("FAIL reset_event got %0b want 0", b_event_o); end
    checks++; if (busy_o !== 1'b0)     begin errors++; $display("FAIL reset_busy got %0b want 0", busy_o); end
    checks++; if (done_o !== 1'b0)     begin errors++; $display("FAIL reset_done got %0b want 0", done_o); end
    checks++; if (err_o !== 1'b0)      begin errors++; $display("FAIL reset_err got %0b want 0", err_o); end
    checks++; if (duty_o !== '0)       begin errors++; $display("FAIL reset_duty got %0d want 0", duty_o); end
    rst_i = 1'b0;
    m_cur = 0;
  endtask

  task automatic run_ramp(input string nm, input int tgt, input int step, input int per, input int ss);
    int p, sp, n, c0, base, t, dn;
    bit to;
    build_model(m_cur, tgt, step);
    n  = exp_d.size();
    p  = (per == 0) ? 1 : per;
    sp = p + 3 + VER;
    c0 = -1000;
    @(posedge clk_i);
    ops.delete();
    dones.delete();
    pulse_start(tgt, step, per, ss, 1'b0);
    to = 1'b1;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk_i);
      if (!busy_o) begin to = 1'b0; break; end
    end
    checks++; if (to) begin errors++; $display("FAIL %s_timeout busy_o=%0b want 0", nm, busy_o); end
    @(posedge clk_i);
    checks++;
    if (ops.size() != 1 + n * (2 + VER)) begin
      errors++; $display("FAIL %s_opcount got %0d want %0d", nm, ops.size(), 1 + n * (2 + VER));
    end else begin
      c0 = ops[0].cyc;
      checks++;
      if (ops[0].addr != 0 || ops[0].data != 128 + ss || ops[0].ev != 2) begin
        errors++; $display("FAIL %s_ctl0 got a=%0h d=%0h e=%0d want a=0 d=%0h e=2", nm, ops[0].addr, ops[0].data, ops[0].ev, 128 + ss);
      end
      for (int k = 0; k < n; k++) begin
        base = 1 + k * (2 + VER);
        t    = c0 + p + 2 + k * sp;
        checks++;
        if (ops[base].addr != 1 || ops[base].data != (exp_d[k] >> 8) || ops[base].ev != 2 || ops[base].cyc != t) begin
          errors++; $display("FAIL %s_hi[%0d] got a=%0h d=%0h t=%0d want a=1 d=%0h t=%0d", nm, k, ops[base].addr, ops[base].data, ops[base].cyc - c0, exp_d[k] >> 8, t - c0);
        end
        checks++;
        if (ops[base+1].addr != 16 || ops[base+1].data != (exp_d[k] % 256) || ops[base+1].ev != 2 || ops[base+1].cyc != t + 1) begin
          errors++; $display("FAIL %s_lo[%0d] got a=%0h d=%0h t=%0d want a=10 d=%0h t=%0d", nm, k, ops[base+1].addr, ops[base+1].data, ops[base+1].cyc - c0, exp_d[k] % 256, t + 1 - c0);
        end
`ifdef PWM_RAMP_CTRL_READBACK_EN
        checks++;
        if (ops[base+2].addr != 16 || ops[base+2].ev != 1 || ops[base+2].cyc != t + 2) begin
          errors++; $display("FAIL %s_rd[%0d] got a=%0h e=%0d t=%0d want a=10 e=1 t=%0d", nm, k, ops[base+2].addr, ops[base+2].ev, ops[base+2].cyc - c0, t + 2 - c0);
        end
`endif
      end
    end
    dn = (n == 0) ? c0 + 1 : c0 + p + 2 + (n - 1) * sp + 2 + VER;
    checks++;
    if (dones.size() != 1 || dones[0] != dn) begin
      errors++; $display("FAIL %s_done got count=%0d t=%0d want count=1 t=%0d", nm, dones.size(), (dones.size() > 0) ? dones[0] - c0 : -1, dn - c0);
    end
    checks++; if (duty_o !== tgt[PW-1:0]) begin errors++; $display("FAIL %s_duty got %0d want %0d", nm, duty_o, tgt); end
    checks++; if (err_o !== exp_err) begin errors++; $display("FAIL %s_err got %0b want %0b", nm, err_o, exp_err); end
    m_cur = tgt;
  endtask

  task automatic test_up_ramp();
    run_ramp("up", 100, 30, 4, 2);
  endtask

  task automatic test_hi_byte();
    run_ramp("hi_up", 900, 255, 3, 1);
    run_ramp("hi_down", 5, 200, 2, 3);
  endtask

  task automatic test_degenerate();
    run_ramp("deg_step", m_cur + 2, 0, 0, 0);
    run_ramp("deg_equal", m_cur, 7, 5, 1);
  endtask

  task automatic test_random();
    int tgt, step, per;
    for (int i = 0; i < 6; i++) begin
      step = $urandom_range(0, 255);
      if (step < 8) begin
        step = 0;
        tgt  = m_cur + $urandom_range(0, 5);
        if (tgt > 1023) tgt = 1023;
      end else begin
        tgt = $urandom_range(0, 1023);
      end
      per = $urandom_range(0, 6);
      run_ramp("rand", tgt, step, per, $urandom_range(0, 3));
    end
  endtask

  task automatic check_stop_tail(input string nm, input int want_duty);
    @(negedge clk_i);
    stop_i = 1'b0;
    checks++;
    if (b_event_o !== 2'b10 || b_addr_o !== 8'h00 || b_data_o !== 8'h00 || busy_o !== 1'b1) begin
      errors++; $display("FAIL %s_stopwr got a=%0h d=%0h e=%0b busy=%0b want a=0 d=0 e=10 busy=1", nm, b_addr_o, b_data_o, b_event_o, busy_o);
    end
    @(negedge clk_i);
    checks++; if (busy_o !== 1'b0 || b_event_o !== 2'b00) begin errors++; $display("FAIL %s_idle got busy=%0b e=%0b want 0 0", nm, busy_o, b_event_o); end
    checks++; if (dones.size() != 0) begin errors++; $display("FAIL %s_nodone got %0d pulses want 0", nm, dones.size()); end
    checks++; if (duty_o !== want_duty[PW-1:0]) begin errors++; $display("FAIL %s_duty got %0d want %0d", nm, duty_o, want_duty); end
    m_cur = want_duty;
  endtask

  task automatic test_abort_wait();
    int tgt;
    tgt = (m_cur >= 512) ? 0 : 1023;
    @(posedge clk_i);
    dones.delete();
    pulse_start(tgt, 10, 10, 1, 1'b0);
    @(negedge clk_i);
    stop_i = 1'b1;
    check_stop_tail("abort_wait", m_cur);
  endtask

  task automatic test_abort_wr_hi();
    int tgt;
    bit to;
    tgt = (m_cur >= 512) ? m_cur - 50 : m_cur + 50;
    build_model(m_cur, tgt, 10);
    @(posedge clk_i);
    dones.delete();
    pulse_start(tgt, 10, 2, 0, 1'b0);
    to = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      if (b_event_o == 2'b10 && b_addr_o == 8'h01) begin to = 1'b0; break; end
    end
    checks++; if (to) begin errors++; $display("FAIL abort_hi_timeout no hi write seen want one"); end
    stop_i = 1'b1;
    check_stop_tail("abort_hi", exp_d[0]);
  endtask

  task automatic test_contention_reset();
    pulse_start((m_cur >= 512) ? 0 : 1023, 20, 5, 3, 1'b1);
    checks++;
    if (busy_o !== 1'b1 || b_event_o !== 2'b10 || b_addr_o !== 8'h00 || b_data_o !== 8'h83) begin
      errors++; $display("FAIL contention got busy=%0b e=%0b a=%0h d=%0h want 1 10 0 83", busy_o, b_event_o, b_addr_o, b_data_o);
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || b_event_o !== 2'b00 || b_addr_o !== 8'h00 || b_data_o !== 8'h00 || err_o !== 1'b0) begin
      errors++; $display("FAIL midreset got busy=%0b done=%0b e=%0b a=%0h d=%0h err=%0b want all 0", busy_o, done_o, b_event_o, b_addr_o, b_data_o, err_o);
    end
    checks++; if (duty_o !== '0) begin errors++; $display("FAIL midreset_duty got %0d want 0", duty_o); end
    m_cur = 0;
    exp_err = 1'b0;
  endtask

`ifdef PWM_RAMP_CTRL_READBACK_EN
  task automatic test_readback();
    int seen;
    bit to;
    do_reset();
    @(posedge clk_i);
    dones.delete();
    pulse_start(100, 30, 3, 2, 1'b0);
    seen = 0;
    to = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i);
      if (b_event_o == 2'b01) begin
        seen++;
        if (seen == 2) begin to = 1'b0; break; end
        @(negedge clk_i);
        force_bad = 1'b1;
      end
    end
    checks++; if (to) begin errors++; $display("FAIL rb_timeout reads=%0d want 2", seen); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rb_err_early got %0b want 0", err_o); end
    @(negedge clk_i);
    force_bad = 1'b0;
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL rb_err got %0b want 1", err_o); end
    checks++;
    if (b_event_o !== 2'b10 || b_addr_o !== 8'h00 || b_data_o !== 8'h00) begin
      errors++; $display("FAIL rb_stopwr got a=%0h d=%0h e=%0b want 0 0 10", b_addr_o, b_data_o, b_event_o);
    end
    @(negedge clk_i);
    checks++; if (busy_o !== 1'b0 || dones.size() != 0) begin errors++; $display("FAIL rb_idle got busy=%0b dones=%0d want 0 0", busy_o, dones.size()); end
    checks++; if (duty_o !== 10'd60) begin errors++; $display("FAIL rb_duty got %0d want 60", duty_o); end
    m_cur = 60;
    exp_err = 1'b1;
    run_ramp("rb_sticky", 60, 0, 0, 0);
  endtask
`endif

  initial begin
    test_reset();
    test_up_ramp();
    test_hi_byte();
    test_abort_wait();
    test_abort_wr_hi();
    test_contention_reset();
    test_degenerate();
    test_random();
`ifdef PWM_RAMP_CTRL_READBACK_EN
    test_readback();
`endif
    do_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
